// File: rtl/mpram_arb.sv
// mpram_arb: shared multi-port scratch RAM plus a small control-register window.
// All ports read in parallel with registered read data. One write per cycle is
// granted by a round-robin arbiter, with byte enables. An access that hits
// neither window is granted and then flagged on err one cycle later.
// Optional macro MPRAM_WRITE_FORWARD_EN: a read of the word being written in
// the same cycle returns the merged new data instead of the old data.
module mpram_arb #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1200,
    parameter int PORTS     = 2,
    parameter int BASE      = 206800,
    parameter int CTRL_BASE = 411698,
    parameter int NCTRL     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         req,
    input  logic [PORTS-1:0]         we,
    input  logic [PORTS*WIDTH-1:0]   addr,
    input  logic [PORTS*WIDTH-1:0]   wdata,
    input  logic [PORTS*WIDTH/8-1:0] be,
    output logic [PORTS-1:0]         gnt,
    output logic [PORTS-1:0]         rvalid,
    output logic [PORTS*WIDTH-1:0]   rdata,
    output logic [PORTS-1:0]         err
);
    localparam int NB = WIDTH / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (NCTRL > 1) ? $clog2(NCTRL) : 1;
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [WIDTH-1:0] BASE_W      = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] CTRL_BASE_W = WIDTH'(CTRL_BASE);
    localparam logic [WIDTH-1:0] DEPTH_W     = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] NCTRL_W     = WIDTH'(NCTRL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ctrl_word [NCTRL];

    logic [WIDTH-1:0] p_addr   [PORTS];
    logic [WIDTH-1:0] p_wdata  [PORTS];
    logic [NB-1:0]    p_be     [PORTS];
    logic [WIDTH-1:0] mem_off  [PORTS];
    logic [WIDTH-1:0] ctrl_off [PORTS];
    logic [PORTS-1:0] mem_hit;
    logic [PORTS-1:0] ctrl_hit;
    logic [PORTS-1:0] mapped;
    logic [PORTS-1:0] rd_gnt;

    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_next;
    logic [PW-1:0]    win;
    logic [PORTS-1:0] wr_req;
    logic [PORTS-1:0] wr_gnt;
    logic             wr_fire;

    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_mask;
    logic [NB-1:0]    w_be;
    logic [AW-1:0]    w_midx;
    logic [CW-1:0]    w_cidx;
    logic             w_mem_hit;
    logic             w_ctrl_hit;

    // Per-port unpacking and address decode; offsets wrap so addresses below a base miss
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_dec
        assign p_addr[gi]   = addr[gi*WIDTH +: WIDTH];
        assign p_wdata[gi]  = wdata[gi*WIDTH +: WIDTH];
        assign p_be[gi]     = be[gi*NB +: NB];
        assign mem_off[gi]  = p_addr[gi] - BASE_W;
        assign ctrl_off[gi] = p_addr[gi] - CTRL_BASE_W;
        assign mem_hit[gi]  = (mem_off[gi] < DEPTH_W);
        assign ctrl_hit[gi] = ~mem_hit[gi] & (ctrl_off[gi] < NCTRL_W);
    end

    assign mapped = mem_hit | ctrl_hit;
    assign wr_req = req & we;

    // Round-robin search for the first write requester starting at the pointer
    always_comb begin
        logic [PW:0] cand;
        wr_fire = 1'b0;
        win     = ptr_reg;
        cand    = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand = {1'b0, ptr_reg} + (PW+1)'(k);
            if (cand >= (PW+1)'(PORTS)) begin
                cand = cand - (PW+1)'(PORTS);
            end
            if (!wr_fire && wr_req[cand[PW-1:0]]) begin
                wr_fire = 1'b1;
                win     = cand[PW-1:0];
            end
        end
        if (rst) begin
            wr_fire = 1'b0;
        end
    end

    // Pointer advances past the winner only when a write was granted
    always_comb begin
        ptr_next = ptr_reg;
        if (wr_fire) begin
            ptr_next = (win == PW'(PORTS - 1)) ? '0 : win + 1'b1;
        end
    end

    assign wr_gnt = wr_fire ? (PORTS'(1) << win) : '0;
    assign gnt    = rst ? '0 : ((req & ~we) | wr_gnt);
    assign rd_gnt = gnt & ~we;

    assign w_wdata    = p_wdata[win];
    assign w_be       = p_be[win];
    assign w_mem_hit  = mem_hit[win];
    assign w_ctrl_hit = ctrl_hit[win];
    assign w_midx     = AW'(mem_off[win]);
    assign w_cidx     = CW'(ctrl_off[win]);

    for (genvar gb = 0; gb < NB; gb++) begin : g_mask
        assign w_mask[gb*8 +: 8] = {8{w_be[gb]}};
    end

`ifdef MPRAM_WRITE_FORWARD_EN
    logic [WIDTH-1:0] w_addr;
    assign w_addr = p_addr[win];
`endif

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Memory write: only the enabled byte lanes change; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire && w_mem_hit) begin
            mem[w_midx] <= (mem[w_midx] & ~w_mask) | (w_wdata & w_mask);
        end
    end

    for (genvar gc = 0; gc < NCTRL; gc++) begin : g_ctrl
        logic [WIDTH-1:0] value_reg;
        // Control register with byte-lane write, cleared by reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                value_reg <= '0;
            end else if (wr_fire && w_ctrl_hit && (w_cidx == CW'(gc))) begin
                value_reg <= (value_reg & ~w_mask) | (w_wdata & w_mask);
            end
        end
        assign ctrl_word[gc] = value_reg;
    end

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_rd
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] rdata_reg;
        logic             rvalid_reg;
        logic             err_reg;

        // Select the word this port would read; unmapped reads yield zero
        always_comb begin
            word = '0;
            if (mem_hit[gi]) begin
                word = mem[AW'(mem_off[gi])];
            end else if (ctrl_hit[gi]) begin
                word = ctrl_word[CW'(ctrl_off[gi])];
            end
`ifdef MPRAM_WRITE_FORWARD_EN
            if (wr_fire && mapped[gi] && (p_addr[gi] == w_addr)) begin
                word = (word & ~w_mask) | (w_wdata & w_mask);
            end
`endif
        end

        // Registered read response and error pulse; rdata holds between reads
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_reg  <= '0;
                rvalid_reg <= 1'b0;
                err_reg    <= 1'b0;
            end else begin
                rvalid_reg <= rd_gnt[gi] & mapped[gi];
                err_reg    <= gnt[gi] & ~mapped[gi];
                if (rd_gnt[gi]) begin
                    rdata_reg <= word;
                end
            end
        end

        assign rdata[gi*WIDTH +: WIDTH] = rdata_reg;
        assign rvalid[gi]               = rvalid_reg;
        assign err[gi]                  = err_reg;
    end

endmodule

// File: doc/mpram_arb.md
Name: mpram_arb

Overview:
- Single-clock, parametrised successor to the team's shared scratch RAM between CPU and JPEG datapath masters.
- PORTS request/grant masters share one word-addressed memory window plus a small control-register window.
- All ports read in parallel with registered read data; writes use round-robin arbitration, one per cycle, with byte enables.
- Unmapped accesses are flagged per port instead of being silently ignored.

Parameters:
WIDTH, 32, data and address width in bits; multiple of 8
DEPTH, 1200, memory words
PORTS, 2, number of master ports (2..8)
BASE, 206800, word address of memory[0]
CTRL_BASE, 411698, word address of control register 0
NCTRL, 2, number of control registers (1..4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  PORTS  per-port access request
we  in  PORTS  1 = write, 0 = read (valid with req)
addr  in  PORTS*WIDTH  word address, port p at bits [p*WIDTH +: WIDTH]
wdata  in  PORTS*WIDTH  write data, same packing
be  in  PORTS*WIDTH/8  byte enables, port p at [p*WIDTH/8 +: WIDTH/8]
gnt  out  PORTS  combinational grant, access accepted this cycle
rvalid  out  PORTS  registered, rdata valid for the read granted last cycle
rdata  out  PORTS*WIDTH  registered read data
err  out  PORTS  registered, pulses 1 cycle after a granted unmapped access

Behaviour:
- Decode per port, unsigned WIDTH-bit math:
  - mem hit if (addr-BASE) < DEPTH; the wrap makes addresses below BASE miss.
  - ctrl hit if (addr-CTRL_BASE) < NCTRL.
  - mem hit takes priority; neither hit = unmapped.
- Reads: req & ~we gives gnt=1 the same cycle, unconditionally, on all ports in parallel. Next cycle rvalid=1 and rdata=word; unmapped reads return rdata=0 with err=1.
- Writes: among ports with req & we, a round-robin arbiter grants exactly one. Losers get gnt=0 and must hold req/we/addr/wdata/be stable until granted.
  - Priority pointer starts at port 0. After a granted write it moves to winner+1 (mod PORTS); with no write it holds.
  - The granted write updates only byte lanes with be=1 at the rising edge. be=0 is granted as a no-op.
  - An unmapped write is granted and dropped, with err=1 next cycle and rvalid=0.
- Read-during-write, same word, same cycle: the read returns the old (pre-write) data.
- rvalid/err on a port are 0 in any cycle following a cycle with no granted read/unmapped access on that port. rdata holds its last value when rvalid=0.
- Reset (asserted any time, including mid-access):
  - rvalid=0, err=0, rdata=0, control registers=0, priority pointer=0.
  - Memory contents are not reset.
  - gnt is forced 0 while rst=1.
  - An access in flight at reset assertion is lost; the master re-requests.
- Control registers are WIDTH bits, fully read/write, and byte-enable honoured.
- Throughput: every port can complete one read per cycle. Aggregate write rate is one per cycle. The worst-case wait for a writer is PORTS-1 cycles.

Optional Feature:
- MPRAM_WRITE_FORWARD_EN defined: a read hitting the same mapped word as the granted write in the same cycle returns the merged new data (old bytes where be=0, wdata where be=1).
- Undefined: the read returns the old data as stated above. All other behaviour is identical.

Test Plan:
1. Reset, then port0 writes 0xDEADBEEF at 206800 with be=0xF, then port1 reads 206800 -> gnt1=1; next cycle rvalid1=1, rdata1=0xDEADBEEF, err1=0.
2. Both ports write the same cycle and hold their requests (ptr=0) -> cycle0 gnt=2'b01, cycle1 gnt=2'b10; the pointer then sits at 0. Repeat with ptr=1 -> port1 is granted first.
3. Byte enables: word=0x11223344, write 0xAABBCCDD with be=0x5 -> readback 0x11BB33DD.
4. Boundaries: read 208000 (=BASE+DEPTH), read 206799, and write 411700 -> each gets gnt=1, then err=1, rdata=0 for the reads; memory is unchanged. 411698/411699 write-read back correctly.
5. Same-cycle read and write to 207000 (old 0x1, new 0x2) -> rdata=0x1 without the macro, 0x2 with MPRAM_WRITE_FORWARD_EN.
6. Assert rst while a read is granted and a write is losing arbitration -> next cycle rvalid=0, err=0, rdata=0, gnt=0. After release, port0 wins the first write contest.
